div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Sequencer between the EX stage and the iterative divider. It accepts DIV/DIVU/REM/REMU requests, latches the operands and pulses div_start. It stalls the pipeline until div_done and returns the selected result. A one-entry result cache lets a REM that follows a DIV on the same operands (and vice versa) complete in one cycle without reusing the divider.

Parameters:
CACHE_EN, 1, 1 enables the one-entry quotient/remainder cache; 0 makes every request a miss.
CNT_W, 32, width of the hit and miss performance counters.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX-stage divide-class request; held with operands stable while stall_out=1
ex_op  input  mult_funct3_t  requested op; only DIV/DIVU/REM/REMU are divide-class
ex_rs1  input  32  dividend
ex_rs2  input  32  divisor
flush  input  1  pipeline squash of the current EX instruction
stall_out  output  1  hold the EX stage
result  output  32  quotient or remainder per ex_op
result_valid  output  1  result valid this cycle (single cycle)
div_start  output  1  one-cycle start pulse to the divider
div_op  output  mult_funct3_t  latched op to the divider
dividend  output  32  latched rs1
divisor  output  32  latched rs2
quotient  input  32  divider quotient
remainder  input  32  divider remainder
div_done  input  1  divider completion pulse
perf_hits  output  CNT_W  cache-hit count
perf_misses  output  CNT_W  divider-issue count

Behaviour:
- Request: req = ex_valid & ex_op[2], i.e. ops 100/101/110/111. Signed class sgn = ~ex_op[0].
- Hit: CACHE_EN & cv & (c_rs1==ex_rs1) & (c_rs2==ex_rs2) & (c_sgn==sgn).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, req & hit & ~flush:
  - stall_out=0, result_valid=1.
  - result = ex_op[1] ? c_rem : c_quo, combinational from cache.
  - perf_hits increments.
- IDLE, req & hit & flush: result_valid=0, stall_out=0, no count.
- IDLE, req & ~hit & ~flush:
  - stall_out=1.
  - Latch op/rs1/rs2 into div_op/dividend/divisor.
  - Go to ISSUE.
- IDLE, req & ~hit & flush: stay in IDLE, stall_out=0.
- ISSUE:
  - div_start=1 for exactly this cycle, stall_out=1, perf_misses increments, go to WAIT.
  - If flush this cycle: div_start=0, no count, go to IDLE.
- WAIT:
  - stall_out=1 whenever req, else 0.
  - On div_done: c_quo<=quotient, c_rem<=remainder, c_rs1/c_rs2/c_sgn<=latched values, cv<=1; go to IDLE.
  - Flush in WAIT does not abort; the divider cannot be aborted. The result is still cached.
- After a miss, the next IDLE cycle is a guaranteed hit. Miss latency = divider cycles + 2 stall cycles beyond div_done-less overhead: accept cycle, ISSUE, WAIT..., result in the first IDLE cycle after div_done.
- With CACHE_EN=0:
  - Hit is forced 0. cv is still written.
  - The cycle after div_done, the result is taken from the holding register when the latched operands still match. This is the same compare; only the enable differs for the post-done cycle.
  - Implement as a hit when (CACHE_EN | just_done).
- div_op/dividend/divisor only change in IDLE on a miss accept. They are stable throughout ISSUE/WAIT.
- No new issue while in ISSUE/WAIT; only one divide is outstanding.
- Non-divide ops (ex_op[2]=0): ignored, stall_out=0, result_valid=0.
- Simultaneous div_done and flush in WAIT: the cache is written and the FSM returns to IDLE.
- Counters wrap at 2^CNT_W.
- Reset, including mid-WAIT (the divider resets on the same rst):
  - FSM=IDLE, cv=0, all cache and latch registers 0.
  - div_start=0, stall_out=0, result_valid=0, result=0.
  - div_op=DIV, dividend=0, divisor=0, perf_hits=0, perf_misses=0.
- Divide-by-zero and overflow are handled by the divider. This block passes its results through unchanged.

Decomposition:
- mult_funct3 package: mult_funct3_t and the op encodings. Add to it the div_ctrl_state_t enum (IDLE/ISSUE/WAIT) and the helper constants IS_DIV_BIT=2, IS_REM_BIT=1, IS_UNSIGNED_BIT=0.
- One natural sub-module, div_result_cache: the registered entry, the compare and the quo/rem select. The FSM and counters stay in the top.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, then REM on the same operands: DIV gets one div_start, result 0xFFFFFFFD. REM completes in 1 cycle with result 0xFFFFFFFF, no div_start; perf_hits=1, perf_misses=1.
- DIV -7/2, then DIVU 0xFFFFFFF9/2: the sign class differs, so a miss. A second div_start fires and the result is 0x7FFFFFFC.
- DIVU 5/0, then REMU 5/0: quotient 0xFFFFFFFF via the divider, then a cache hit with remainder 0x00000005.
- Miss with flush asserted in the ISSUE cycle: div_start is never pulsed, the FSM returns to IDLE, perf_misses is unchanged.
- Flush in WAIT, then a new DIV 100/7 while the divider is busy: stall_out stays 1 until div_done. The stale entry is cached, the new request misses, and the result is 0x0000000E.
- rst asserted mid-WAIT: the next cycle shows every output at its reset value and cv=0. A replay of the same DIV re-issues div_start.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the divide issue controller: M-extension funct3 encodings,
// sequencer states and the funct3 bit positions that classify a divide op.
package div_issue_ctrl_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mult_funct3_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } div_ctrl_state_t;

   localparam int IS_DIV_BIT      = 2;
   localparam int IS_REM_BIT      = 1;
   localparam int IS_UNSIGNED_BIT = 0;

endpackage

// File: rtl/div_result_cache.sv
// One-entry quotient/remainder store keyed by operands and sign class,
// with the lookup compare and the quotient/remainder output select.
module div_result_cache (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en_i,
   input  logic [31:0] wr_quo_i,
   input  logic [31:0] wr_rem_i,
   input  logic [31:0] wr_rs1_i,
   input  logic [31:0] wr_rs2_i,
   input  logic        wr_sgn_i,
   input  logic        cmp_en_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        sgn_i,
   input  logic        rem_sel_i,
   output logic        hit_o,
   output logic [31:0] data_o
);

   logic        cv_q;
   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] rs1_q;
   logic [31:0] rs2_q;
   logic        sgn_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cv_q  <= 1'b0;
         quo_q <= '0;
         rem_q <= '0;
         rs1_q <= '0;
         rs2_q <= '0;
         sgn_q <= 1'b0;
      end else if (wr_en_i) begin
         cv_q  <= 1'b1;
         quo_q <= wr_quo_i;
         rem_q <= wr_rem_i;
         rs1_q <= wr_rs1_i;
         rs2_q <= wr_rs2_i;
         sgn_q <= wr_sgn_i;
      end
   end

   assign hit_o  = cmp_en_i & cv_q & (rs1_q == rs1_i) & (rs2_q == rs2_i) & (sgn_q == sgn_i);
   assign data_o = rem_sel_i ? rem_q : quo_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-to-divider sequencer: issues one divide at a time, stalls EX until the
// result is back, and serves DIV/REM pairs on equal operands from a result cache.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter bit CACHE_EN = 1'b1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  mult_funct3_t     ex_op,
   input  logic [31:0]      ex_rs1,
   input  logic [31:0]      ex_rs2,
   input  logic             flush,
   output logic             stall_out,
   output logic [31:0]      result,
   output logic             result_valid,
   output logic             div_start,
   output mult_funct3_t     div_op,
   output logic [31:0]      dividend,
   output logic [31:0]      divisor,
   input  logic [31:0]      quotient,
   input  logic [31:0]      remainder,
   input  logic             div_done,
   output logic [CNT_W-1:0] perf_hits,
   output logic [CNT_W-1:0] perf_misses
);

   div_ctrl_state_t  state_q, state_d;
   mult_funct3_t     op_q;
   logic [31:0]      rs1_q, rs2_q;
   logic [CNT_W-1:0] hits_q, misses_q;
   logic             just_done_q;

   logic        req, sgn, hit, cmp_en;
   logic        latch_en, hit_inc, miss_inc, cache_wr;
   logic [31:0] cache_data;

   assign req = ex_valid & ex_op[IS_DIV_BIT];
   assign sgn = ~ex_op[IS_UNSIGNED_BIT];
   // Without the cache, the entry is still consulted in the cycle right after
   // div_done so the stalled request can pick up its own result.
   assign cmp_en = CACHE_EN | just_done_q;

   div_result_cache u_cache (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (cache_wr),
      .wr_quo_i (quotient),
      .wr_rem_i (remainder),
      .wr_rs1_i (rs1_q),
      .wr_rs2_i (rs2_q),
      .wr_sgn_i (~op_q[IS_UNSIGNED_BIT]),
      .cmp_en_i (cmp_en),
      .rs1_i    (ex_rs1),
      .rs2_i    (ex_rs2),
      .sgn_i    (sgn),
      .rem_sel_i(ex_op[IS_REM_BIT]),
      .hit_o    (hit),
      .data_o   (cache_data)
   );

   always_comb begin
      state_d      = state_q;
      stall_out    = 1'b0;
      result_valid = 1'b0;
      result       = '0;
      div_start    = 1'b0;
      latch_en     = 1'b0;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      cache_wr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && !flush) begin
               if (hit) begin
                  result_valid = 1'b1;
                  result       = cache_data;
                  // Delivering a just-finished miss is not a cache hit.
                  hit_inc      = ~just_done_q;
               end else begin
                  stall_out = 1'b1;
                  latch_en  = 1'b1;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            stall_out = 1'b1;
            if (flush) begin
               state_d = IDLE;
            end else begin
               div_start = 1'b1;
               miss_inc  = 1'b1;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            stall_out = req;
            if (div_done) begin
               cache_wr = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= DIV;
         rs1_q       <= '0;
         rs2_q       <= '0;
         hits_q      <= '0;
         misses_q    <= '0;
         just_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         just_done_q <= cache_wr;
         if (latch_en) begin
            op_q  <= ex_op;
            rs1_q <= ex_rs1;
            rs2_q <= ex_rs2;
         end
         if (hit_inc)  hits_q   <= hits_q + CNT_W'(1);
         if (miss_inc) misses_q <= misses_q + CNT_W'(1);
      end
   end

   assign div_op      = op_q;
   assign dividend    = rs1_q;
   assign divisor     = rs2_q;
   assign perf_hits   = hits_q;
   assign perf_misses = misses_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a fixed-latency divider stand-in.
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ex_valid = 1'b0;
   mult_funct3_t ex_op = MUL;
   logic [31:0]  ex_rs1 = '0, ex_rs2 = '0;
   logic         flush = 1'b0;
   logic         stall_out, result_valid, div_start;
   logic [31:0]  result, dividend, divisor;
   mult_funct3_t div_op;
   logic [31:0]  quotient = '0, remainder = '0;
   logic         div_done = 1'b0;
   logic [31:0]  perf_hits, perf_misses;

   int          nvec = 0, nbad = 0;
   int          starts = 0, dcnt = 0;
   logic [31:0] dq, dr;

   always #5 clk = ~clk;

   div_issue_ctrl #(.CACHE_EN(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .flush(flush), .stall_out(stall_out), .result(result),
      .result_valid(result_valid), .div_start(div_start), .div_op(div_op),
      .dividend(dividend), .divisor(divisor), .quotient(quotient),
      .remainder(remainder), .div_done(div_done), .perf_hits(perf_hits),
      .perf_misses(perf_misses)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // RISC-V divide semantics for the divider stand-in
   task automatic ref_div(input mult_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF; r = a;
      end else if (!op[0]) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = a; r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b; r = a % b;
      end
   endtask

   // One clock: drive at negedge, run the divider stand-in, sample 1ns later.
   task automatic tick(input logic v, input mult_funct3_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic r);
      @(negedge clk);
      ex_valid = v; ex_op = op; ex_rs1 = a; ex_rs2 = b; flush = fl; rst = r;
      div_done = 1'b0;
      if (r) dcnt = 0;
      else if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            div_done = 1'b1; quotient = dq; remainder = dr;
         end
      end
      #1;
      if (div_start && !r) begin
         starts++;
         dcnt = LAT;
         ref_div(div_op, dividend, divisor, dq, dr);
      end
   endtask

   task automatic do_req(input mult_funct3_t op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cyc);
      logic got;
      got = 1'b0; res = '0; cyc = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         tick(1'b1, op, a, b, 1'b0, 1'b0);
         cyc++;
         if (result_valid) begin
            got = 1'b1; res = result;
         end
      end
      if (!got) begin
         nvec++; nbad++;
         $display("FAIL request timeout: got no result_valid expected one within 60 cycles");
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      mult_funct3_t op;
      logic [31:0]  a, b, res;
      int           cyc, dstart, dhit, dmiss;
   } vec_t;

   vec_t        tbl[12];
   logic [31:0] res, h0, m0;
   int          cyc, s0;

   initial begin
      tbl[0]  = '{DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 6, 1, 0, 1};
      tbl[1]  = '{REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1, 0, 1, 0};
      tbl[2]  = '{DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 6, 1, 0, 1};
      tbl[3]  = '{REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 1, 0, 1, 0};
      tbl[4]  = '{DIVU, 32'd5,        32'd0, 32'hFFFFFFFF, 6, 1, 0, 1};
      tbl[5]  = '{REMU, 32'd5,        32'd0, 32'h00000005, 1, 0, 1, 0};
      tbl[6]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6, 1, 0, 1};
      tbl[7]  = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 1, 0};
      tbl[8]  = '{DIV,  32'd100,      32'd7, 32'h0000000E, 6, 1, 0, 1};
      tbl[9]  = '{DIVU, 32'd100,      32'd7, 32'h0000000E, 6, 1, 0, 1};
      tbl[10] = '{REMU, 32'd100,      32'd7, 32'h00000002, 1, 0, 1, 0};
      tbl[11] = '{REM,  32'd100,      32'd7, 32'h00000002, 6, 1, 0, 1};

      tick(1'b0, MUL, '0, '0, 1'b0, 1'b1);
      tick(1'b0, MUL, '0, '0, 1'b0, 1'b1);
      tick(1'b0, DIV, '0, '0, 1'b0, 1'b0);
      chk("reset stall_out", 32'(stall_out), 32'd0);
      chk("reset result_valid", 32'(result_valid), 32'd0);
      chk("reset div_start", 32'(div_start), 32'd0);
      chk("reset div_op", 32'(div_op), 32'(DIV));
      chk("reset dividend", dividend, 32'd0);
      chk("reset perf_misses", perf_misses, 32'd0);

      // Non-divide op is ignored
      tick(1'b1, MUL, 32'd3, 32'd4, 1'b0, 1'b0);
      chk("mul stall_out", 32'(stall_out), 32'd0);
      chk("mul result_valid", 32'(result_valid), 32'd0);
      tick(1'b1, MULHU, 32'd3, 32'd4, 1'b0, 1'b0);
      chk("mul div_start", 32'(div_start), 32'd0);

      // Flush in the ISSUE cycle
      m0 = perf_misses; s0 = starts;
      tick(1'b1, DIV, 32'd33, 32'd4, 1'b0, 1'b0);
      chk("flushiss accept stall", 32'(stall_out), 32'd1);
      tick(1'b1, DIV, 32'd33, 32'd4, 1'b1, 1'b0);
      chk("flushiss div_start", 32'(div_start), 32'd0);
      tick(1'b0, DIV, 32'd33, 32'd4, 1'b0, 1'b0);
      chk("flushiss misses", perf_misses - m0, 32'd0);
      chk("flushiss starts", 32'(starts - s0), 32'd0);
      do_req(DIV, 32'd33, 32'd4, res, cyc);
      chk("flushiss replay result", res, 32'd8);
      chk("flushiss replay cycles", 32'(cyc), 32'd6);

      // Flush in WAIT, then a new DIV while the divider is busy
      m0 = perf_misses; s0 = starts;
      tick(1'b1, DIV, 32'd50, 32'd3, 1'b0, 1'b0);
      tick(1'b1, DIV, 32'd50, 32'd3, 1'b0, 1'b0);
      tick(1'b1, DIV, 32'd50, 32'd3, 1'b1, 1'b0);
      tick(1'b1, DIV, 32'd100, 32'd7, 1'b0, 1'b0);
      chk("flushwait busy stall", 32'(stall_out), 32'd1);
      chk("flushwait busy rv", 32'(result_valid), 32'd0);
      tick(1'b1, DIV, 32'd100, 32'd7, 1'b0, 1'b0);
      chk("flushwait done stall", 32'(stall_out), 32'd1);
      do_req(DIV, 32'd100, 32'd7, res, cyc);
      chk("flushwait result", res, 32'h0000000E);
      chk("flushwait cycles", 32'(cyc), 32'd6);
      chk("flushwait misses", perf_misses - m0, 32'd2);
      chk("flushwait starts", 32'(starts - s0), 32'd2);

      for (int k = 0; k < 12; k++) begin
         s0 = starts; h0 = perf_hits; m0 = perf_misses;
         do_req(tbl[k].op, tbl[k].a, tbl[k].b, res, cyc);
         chk($sformatf("v%0d result", k), res, tbl[k].res);
         chk($sformatf("v%0d cycles", k), 32'(cyc), 32'(tbl[k].cyc));
         chk($sformatf("v%0d starts", k), 32'(starts - s0), 32'(tbl[k].dstart));
         chk($sformatf("v%0d hits", k), perf_hits - h0, 32'(tbl[k].dhit));
         chk($sformatf("v%0d misses", k), perf_misses - m0, 32'(tbl[k].dmiss));
      end

      // Reset in the middle of WAIT drops the cache and the outstanding divide
      do_req(DIV, 32'd77, 32'd5, res, cyc);
      chk("prerst result", res, 32'd15);
      do_req(DIV, 32'd77, 32'd5, res, cyc);
      chk("prerst hit cycles", 32'(cyc), 32'd1);
      tick(1'b1, DIV, 32'd9, 32'd2, 1'b0, 1'b0);
      tick(1'b1, DIV, 32'd9, 32'd2, 1'b0, 1'b0);
      tick(1'b1, DIV, 32'd9, 32'd2, 1'b0, 1'b0);
      tick(1'b0, DIV, 32'd9, 32'd2, 1'b0, 1'b1);
      tick(1'b0, DIV, '0, '0, 1'b0, 1'b0);
      chk("midrst stall_out", 32'(stall_out), 32'd0);
      chk("midrst result_valid", 32'(result_valid), 32'd0);
      chk("midrst result", result, 32'd0);
      chk("midrst div_start", 32'(div_start), 32'd0);
      chk("midrst div_op", 32'(div_op), 32'(DIV));
      chk("midrst dividend", dividend, 32'd0);
      chk("midrst divisor", divisor, 32'd0);
      chk("midrst perf_hits", perf_hits, 32'd0);
      chk("midrst perf_misses", perf_misses, 32'd0);
      s0 = starts;
      do_req(DIV, 32'd77, 32'd5, res, cyc);
      chk("midrst replay result", res, 32'd15);
      chk("midrst replay cycles", 32'(cyc), 32'd6);
      chk("midrst replay starts", 32'(starts - s0), 32'd1);
      chk("midrst replay misses", perf_misses, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
